// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_pkg
// Description : Shared opcodes, fetch-select encodings and the ID/EX control
//               bundle for the 5-stage 32-bit pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] PC_SEQ    = 2'd0;
    localparam logic [1:0] PC_JUMP   = 2'd1;
    localparam logic [1:0] PC_BRANCH = 2'd2;

    // ALU_FUNCT tells execute to decode the R-type funct field itself
    localparam logic [2:0] ALU_FUNCT = 3'd0;
    localparam logic [2:0] ALU_ADD   = 3'd1;
    localparam logic [2:0] ALU_SUB   = 3'd2;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;
    localparam int          NUM_REGS = 32;
    localparam int          LINK_REG = 31;

    localparam int CTRL_REG_WRITE  = 8;
    localparam int CTRL_MEM_READ   = 7;
    localparam int CTRL_MEM_WRITE  = 6;
    localparam int CTRL_MEM_TO_REG = 5;
    localparam int CTRL_ALU_SRC    = 4;
    localparam int CTRL_LINK       = 3;
    localparam int CTRL_ALU_OP_MSB = 2;
    localparam int CTRL_ALU_OP_LSB = 0;
    localparam int CTRL_WIDTH      = 9;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       link;
        logic [2:0] alu_op;
    } ex_ctrl_t;

    localparam ex_ctrl_t CTRL_NOP = '0;

endpackage
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// Module      : register_file
// Description : 32x32 register file, two async read ports with write-first
//               bypass, one write port, r0 hardwired to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module register_file
    import pipeline_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr_a,
    input  logic [4:0]  raddr_b,
    output logic [31:0] rdata_a,
    output logic [31:0] rdata_b
);

    logic [31:0] r_regs [NUM_REGS];
    logic        w_wr_valid;

    assign w_wr_valid = we && (waddr != 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_valid) begin
            r_regs[waddr] <= wdata;
        end
    end

    // A same-cycle write to the read index is forwarded so decode sees it now
    assign rdata_a = (raddr_a == 5'd0)                       ? 32'd0 :
                     (w_wr_valid && (waddr == raddr_a))      ? wdata :
                                                               r_regs[raddr_a];
    assign rdata_b = (raddr_b == 5'd0)                       ? 32'd0 :
                     (w_wr_valid && (waddr == raddr_b))      ? wdata :
                                                               r_regs[raddr_b];

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : IF/ID register, instruction decode, register read, branch and
//               jump resolution, load-use hazard detection and ID/EX register.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage
    import pipeline_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_instruction,
    input  logic [31:0] if_pc_next,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic [1:0]  pc_src,
    output logic [31:0] jump_address,
    output logic [31:0] branch_address,
    output logic        pc_stall,
    output logic [8:0]  ex_ctrl,
    output logic [31:0] ex_rs_data,
    output logic [31:0] ex_rt_data,
    output logic [31:0] ex_imm,
    output logic [31:0] ex_pc_next,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt,
    output logic [4:0]  ex_dest,
    output logic        ex_illegal
);

    logic [31:0] r_if_instr;
    logic [31:0] r_if_pc;
    ex_ctrl_t    r_ex_ctrl;

    logic [5:0]  w_op;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [15:0] w_imm16;
    logic [25:0] w_target;
    logic [31:0] w_imm;
    logic [31:0] w_rs_data;
    logic [31:0] w_rt_data;
    ex_ctrl_t    w_ctrl;
    logic [4:0]  w_dest;
    logic        w_illegal;
    logic        w_reads_rt;
    logic        w_equal;
    logic [1:0]  w_redirect;
    logic        w_hazard;

    assign w_op     = r_if_instr[31:26];
    assign w_rs     = r_if_instr[25:21];
    assign w_rt     = r_if_instr[20:16];
    assign w_rd     = r_if_instr[15:11];
    assign w_imm16  = r_if_instr[15:0];
    assign w_target = r_if_instr[25:0];
    assign w_imm    = {{16{w_imm16[15]}}, w_imm16};

    register_file u_register_file (
        .clk     (clk),
        .rst     (rst),
        .we      (wb_we),
        .waddr   (wb_addr),
        .wdata   (wb_data),
        .raddr_a (w_rs),
        .raddr_b (w_rt),
        .rdata_a (w_rs_data),
        .rdata_b (w_rt_data)
    );

    always_comb begin
        w_ctrl     = CTRL_NOP;
        w_dest     = 5'd0;
        w_illegal  = 1'b0;
        w_reads_rt = 1'b0;
        case (w_op)
            OP_RTYPE: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_op    = ALU_FUNCT;
                w_dest           = w_rd;
                w_reads_rt       = 1'b1;
            end
            OP_ADDI: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.alu_op    = ALU_ADD;
                w_dest           = w_rt;
            end
            OP_LW: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.mem_read   = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
                w_ctrl.alu_src    = 1'b1;
                w_ctrl.alu_op     = ALU_ADD;
                w_dest            = w_rt;
            end
            OP_SW: begin
                w_ctrl.mem_write = 1'b1;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.alu_op    = ALU_ADD;
                w_reads_rt       = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                w_ctrl.alu_op = ALU_SUB;
                w_reads_rt    = 1'b1;
            end
            OP_J: begin
                w_ctrl = CTRL_NOP;
            end
            OP_JAL: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.link      = 1'b1;
                w_dest           = 5'(LINK_REG);
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    assign w_equal = (w_rs_data == w_rt_data);

    always_comb begin
        w_redirect = PC_SEQ;
        if ((w_op == OP_J) || (w_op == OP_JAL)) begin
            w_redirect = PC_JUMP;
        end else if (((w_op == OP_BEQ) && w_equal) || ((w_op == OP_BNE) && !w_equal)) begin
            w_redirect = PC_BRANCH;
        end
    end

    // A load in ID/EX cannot forward in time to a consumer sitting in IF/ID
    assign w_hazard = r_ex_ctrl.mem_read && (ex_dest != 5'd0) &&
                      ((ex_dest == w_rs) || (w_reads_rt && (ex_dest == w_rt)));

    assign pc_stall       = w_hazard;
    assign pc_src         = w_hazard ? PC_SEQ : w_redirect;
    assign jump_address   = {r_if_pc[31:28], w_target, 2'b00};
    assign branch_address = r_if_pc + {w_imm[29:0], 2'b00};
    assign ex_ctrl        = r_ex_ctrl;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_if_instr <= NOP_WORD;
            r_if_pc    <= '0;
        end else if (w_hazard) begin
            r_if_instr <= r_if_instr;
            r_if_pc    <= r_if_pc;
        end else if (pc_src != PC_SEQ) begin
            r_if_instr <= NOP_WORD;
            r_if_pc    <= if_pc_next;
        end else begin
            r_if_instr <= if_instruction;
            r_if_pc    <= if_pc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_hazard) begin
            r_ex_ctrl  <= CTRL_NOP;
            ex_rs_data <= '0;
            ex_rt_data <= '0;
            ex_imm     <= '0;
            ex_pc_next <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_dest    <= '0;
            ex_illegal <= 1'b0;
        end else begin
            r_ex_ctrl  <= w_ctrl;
            ex_rs_data <= w_rs_data;
            ex_rt_data <= w_rt_data;
            ex_imm     <= w_imm;
            ex_pc_next <= r_if_pc;
            ex_rs      <= w_rs;
            ex_rt      <= w_rt;
            ex_dest    <= w_dest;
            ex_illegal <= w_illegal;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage
// Description : Directed, table-driven bench for decode_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_instruction;
    logic [31:0] if_pc_next;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [1:0]  pc_src;
    logic [31:0] jump_address;
    logic [31:0] branch_address;
    logic        pc_stall;
    logic [8:0]  ex_ctrl;
    logic [31:0] ex_rs_data;
    logic [31:0] ex_rt_data;
    logic [31:0] ex_imm;
    logic [31:0] ex_pc_next;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [4:0]  ex_dest;
    logic        ex_illegal;

    int total = 0;
    int bad   = 0;

    decode_stage dut (
        .clk            (clk),
        .rst            (rst),
        .if_instruction (if_instruction),
        .if_pc_next     (if_pc_next),
        .wb_we          (wb_we),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data),
        .pc_src         (pc_src),
        .jump_address   (jump_address),
        .branch_address (branch_address),
        .pc_stall       (pc_stall),
        .ex_ctrl        (ex_ctrl),
        .ex_rs_data     (ex_rs_data),
        .ex_rt_data     (ex_rt_data),
        .ex_imm         (ex_imm),
        .ex_pc_next     (ex_pc_next),
        .ex_rs          (ex_rs),
        .ex_rt          (ex_rt),
        .ex_dest        (ex_dest),
        .ex_illegal     (ex_illegal)
    );

    always #5 clk = ~clk;

    // addr_sel: 0 = no address check, 1 = jump_address, 2 = branch_address
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc_next;
        logic [1:0]  pc_src;
        logic [1:0]  addr_sel;
        logic [31:0] addr;
        logic [8:0]  ctrl;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic [31:0] imm;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic        ill;
    } vec_t;

    function automatic vec_t mk(
        input logic [31:0] instr, input logic [31:0] pc_next,
        input logic [1:0] psrc, input logic [1:0] asel, input logic [31:0] addr,
        input logic [8:0] ctrl, input logic [4:0] rs, input logic [4:0] rt,
        input logic [4:0] dest, input logic [31:0] imm,
        input logic [31:0] rsd, input logic [31:0] rtd, input logic ill);
        vec_t v;
        v.instr = instr;   v.pc_next = pc_next; v.pc_src = psrc;
        v.addr_sel = asel; v.addr = addr;       v.ctrl = ctrl;
        v.rs = rs;         v.rt = rt;           v.dest = dest;
        v.imm = imm;       v.rs_data = rsd;     v.rt_data = rtd;
        v.ill = ill;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
        if_instruction = instr;
        if_pc_next     = pc;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " ex_ctrl"},    32'(ex_ctrl), 32'h0);
        chk({tag, " ex_rs_data"}, ex_rs_data, 32'h0);
        chk({tag, " ex_rt_data"}, ex_rt_data, 32'h0);
        chk({tag, " ex_imm"},     ex_imm, 32'h0);
        chk({tag, " ex_pc_next"}, ex_pc_next, 32'h0);
        chk({tag, " ex_rs"},      32'(ex_rs), 32'h0);
        chk({tag, " ex_rt"},      32'(ex_rt), 32'h0);
        chk({tag, " ex_dest"},    32'(ex_dest), 32'h0);
        chk({tag, " ex_illegal"}, 32'(ex_illegal), 32'h0);
        chk({tag, " pc_src"},     32'(pc_src), 32'h0);
        chk({tag, " pc_stall"},   32'(pc_stall), 32'h0);
    endtask

    vec_t vecs[12];

    initial begin
        // ctrl bits: reg_write mem_read mem_write mem_to_reg alu_src link alu_op[2:0]
        vecs[0]  = mk(32'h20080005, 32'h0000_0004, 2'd0, 2'd0, 32'h0,        9'h111, 5'd0, 5'd8, 5'd8,  32'h5,        32'd0, 32'd0, 1'b0);
        vecs[1]  = mk(32'h10220003, 32'h0000_0100, 2'd2, 2'd2, 32'h10C,      9'h002, 5'd1, 5'd2, 5'd0,  32'h3,        32'd7, 32'd7, 1'b0);
        vecs[2]  = mk(32'h10230003, 32'h0000_0100, 2'd0, 2'd2, 32'h10C,      9'h002, 5'd1, 5'd3, 5'd0,  32'h3,        32'd7, 32'd8, 1'b0);
        vecs[3]  = mk(32'h14230003, 32'h0000_0100, 2'd2, 2'd2, 32'h10C,      9'h002, 5'd1, 5'd3, 5'd0,  32'h3,        32'd7, 32'd8, 1'b0);
        vecs[4]  = mk(32'h14220003, 32'h0000_0100, 2'd0, 2'd2, 32'h10C,      9'h002, 5'd1, 5'd2, 5'd0,  32'h3,        32'd7, 32'd7, 1'b0);
        vecs[5]  = mk(32'h0C000040, 32'h8000_0010, 2'd1, 2'd1, 32'h80000100, 9'h108, 5'd0, 5'd0, 5'd31, 32'h40,       32'd0, 32'd0, 1'b0);
        vecs[6]  = mk(32'h08000010, 32'h0000_0200, 2'd1, 2'd1, 32'h40,       9'h000, 5'd0, 5'd0, 5'd0,  32'h10,       32'd0, 32'd0, 1'b0);
        vecs[7]  = mk(32'h8C24FFFC, 32'h0000_0014, 2'd0, 2'd0, 32'h0,        9'h1B1, 5'd1, 5'd4, 5'd4,  32'hFFFFFFFC, 32'd7, 32'd0, 1'b0);
        vecs[8]  = mk(32'hAC430008, 32'h0000_0018, 2'd0, 2'd0, 32'h0,        9'h051, 5'd2, 5'd3, 5'd0,  32'h8,        32'd7, 32'd8, 1'b0);
        vecs[9]  = mk(32'h00232820, 32'h0000_001C, 2'd0, 2'd0, 32'h0,        9'h100, 5'd1, 5'd3, 5'd5,  32'h2820,     32'd7, 32'd8, 1'b0);
        vecs[10] = mk(32'hFC000000, 32'h0000_0020, 2'd0, 2'd0, 32'h0,        9'h000, 5'd0, 5'd0, 5'd0,  32'h0,        32'd0, 32'd0, 1'b1);
        vecs[11] = mk(32'h1000FFFF, 32'h0000_0000, 2'd2, 2'd2, 32'hFFFFFFFC, 9'h002, 5'd0, 5'd0, 5'd0,  32'hFFFFFFFF, 32'd0, 32'd0, 1'b0);

        rst = 1'b1; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
        drive(32'h0, 32'h0);
        tick();
        chk_all_zero("reset");
        rst = 1'b0;

        // Preload r1 = 7, r2 = 7, r3 = 8
        wb_we = 1'b1;
        wb_addr = 5'd1; wb_data = 32'd7; tick();
        wb_addr = 5'd2; wb_data = 32'd7; tick();
        wb_addr = 5'd3; wb_data = 32'd8; tick();
        wb_we = 1'b0;

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].instr, vecs[i].pc_next);
            tick();
            chk($sformatf("v%0d pc_src", i),   32'(pc_src), 32'(vecs[i].pc_src));
            chk($sformatf("v%0d pc_stall", i), 32'(pc_stall), 32'h0);
            if (vecs[i].addr_sel == 2'd1)
                chk($sformatf("v%0d jump_address", i), jump_address, vecs[i].addr);
            else if (vecs[i].addr_sel == 2'd2)
                chk($sformatf("v%0d branch_address", i), branch_address, vecs[i].addr);
            drive(32'h0, 32'h0);
            tick();
            chk($sformatf("v%0d ex_ctrl", i),    32'(ex_ctrl), 32'(vecs[i].ctrl));
            chk($sformatf("v%0d ex_rs", i),      32'(ex_rs), 32'(vecs[i].rs));
            chk($sformatf("v%0d ex_rt", i),      32'(ex_rt), 32'(vecs[i].rt));
            chk($sformatf("v%0d ex_dest", i),    32'(ex_dest), 32'(vecs[i].dest));
            chk($sformatf("v%0d ex_imm", i),     ex_imm, vecs[i].imm);
            chk($sformatf("v%0d ex_rs_data", i), ex_rs_data, vecs[i].rs_data);
            chk($sformatf("v%0d ex_rt_data", i), ex_rt_data, vecs[i].rt_data);
            chk($sformatf("v%0d ex_pc_next", i), ex_pc_next, vecs[i].pc_next);
            chk($sformatf("v%0d ex_illegal", i), 32'(ex_illegal), 32'(vecs[i].ill));
        end

        // Write-first bypass: ADD r10,r9,r0 in IF/ID while r9 is being written
        drive(32'h01205020, 32'h40); tick();
        wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'hDEADBEEF;
        drive(32'h0, 32'h0); tick();
        chk("bypass ex_rs_data", ex_rs_data, 32'hDEADBEEF);
        wb_addr = 5'd0; wb_data = 32'h12345678;
        drive(32'h00005020, 32'h44); tick();
        drive(32'h0, 32'h0); tick();
        chk("r0 write ignored rs", ex_rs_data, 32'h0);
        chk("r0 write ignored rt", ex_rt_data, 32'h0);
        wb_we = 1'b0;
        drive(32'h01205020, 32'h48); tick();
        drive(32'h0, 32'h0); tick();
        chk("r9 retained", ex_rs_data, 32'hDEADBEEF);

        // Taken branch flushes the wrong-path ADDI out of IF/ID
        drive(32'h10220003, 32'h100); tick();
        chk("flush pc_src", 32'(pc_src), 32'd2);
        drive(32'h20080005, 32'h104); tick();
        chk("flush ex_ctrl branch", 32'(ex_ctrl), 32'h002);
        drive(32'h0, 32'h0); tick();
        chk("flush ex_ctrl nop", 32'(ex_ctrl), 32'h100);
        chk("flush ex_dest", 32'(ex_dest), 32'd0);

        // Not-taken branch lets the following ADDI through
        drive(32'h10230003, 32'h100); tick();
        chk("nt pc_src", 32'(pc_src), 32'd0);
        drive(32'h20080005, 32'h104); tick();
        drive(32'h0, 32'h0); tick();
        chk("nt ex_ctrl addi", 32'(ex_ctrl), 32'h111);
        chk("nt ex_dest", 32'(ex_dest), 32'd8);

        // Load-use on rs: LW r4 then ADD r5,r4,r6
        drive(32'h8C24FFFC, 32'h200); tick();
        drive(32'h00862820, 32'h204); tick();
        chk("lu pc_stall", 32'(pc_stall), 32'd1);
        chk("lu pc_src", 32'(pc_src), 32'd0);
        chk("lu ex_ctrl lw", 32'(ex_ctrl), 32'h1B1);
        drive(32'h20080005, 32'h208); tick();
        chk("lu bubble ex_ctrl", 32'(ex_ctrl), 32'h0);
        chk("lu bubble ex_dest", 32'(ex_dest), 32'd0);
        chk("lu bubble ex_illegal", 32'(ex_illegal), 32'd0);
        chk("lu stall released", 32'(pc_stall), 32'd0);
        drive(32'h0, 32'h0); tick();
        chk("lu add ex_rs", 32'(ex_rs), 32'd4);
        chk("lu add ex_rt", 32'(ex_rt), 32'd6);
        chk("lu add ex_dest", 32'(ex_dest), 32'd5);
        chk("lu add ex_ctrl", 32'(ex_ctrl), 32'h100);

        // Load-use on rt through SW; ADDI rt and LW to r0 must not stall
        drive(32'h8C24FFFC, 32'h300); tick();
        drive(32'hAC440000, 32'h304); tick();
        chk("lu sw rt stall", 32'(pc_stall), 32'd1);
        drive(32'h0, 32'h0); tick();
        tick();
        drive(32'h8C24FFFC, 32'h310); tick();
        drive(32'h20040005, 32'h314); tick();
        chk("lu addi no stall", 32'(pc_stall), 32'd0);
        drive(32'h8C200000, 32'h318); tick();
        drive(32'h00002820, 32'h31C); tick();
        chk("lu r0 no stall", 32'(pc_stall), 32'd0);
        drive(32'h0, 32'h0); tick();

        // Reset in the middle of a stall clears everything, registers included
        drive(32'h8C24FFFC, 32'h400); tick();
        drive(32'h00862820, 32'h404); tick();
        chk("rst stall active", 32'(pc_stall), 32'd1);
        rst = 1'b1; tick();
        chk_all_zero("rst in stall");
        rst = 1'b0;
        drive(32'h00232820, 32'h408); tick();
        drive(32'h0, 32'h0); tick();
        chk("rst cleared r1", ex_rs_data, 32'h0);
        chk("rst cleared r3", ex_rt_data, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
